// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex code table, blank pattern, sampler FSM encoding.
// Pure definitions, no timing; used by the sampler and the hex-to-segment encoder.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } seg7_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] num;
    } seg7_dec_t;

    // Segment order abcdefg, bit 6 = a, 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            4'hF: seg = 7'h47;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
        seg7_dec_t dec;
        dec.hit = 1'b0;
        dec.num = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == hex_to_seg(4'(i))) begin
                dec.hit = 1'b1;
                dec.num = 4'(i);
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Synchronizes SEG and counts identical samples; o_stable strobes as the count reaches STABLE_CYC.
// Latency: o_s lags i_seg by SYNC_STAGES edges; o_stable/o_changed are combinational. No backpressure.
module seg7_stable_filter #(
    parameter int STABLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [6:0] i_seg,
    output logic [6:0] o_s,
    output logic       o_changed,
    output logic       o_stable
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    logic [6:0] r_sync [SYNC_STAGES];
    logic [6:0] r_prev;
    logic [7:0] r_cnt;

    logic [6:0] w_s;
    logic       w_changed;
    logic [7:0] w_cnt_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_changed = (w_s != r_prev);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_changed) begin
            w_cnt_nxt = 8'd1;
        end else if (r_cnt != STABLE) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 7'h00;
            end
            r_prev <= 7'h00;
            r_cnt  <= 8'd1;
        end else begin
            r_sync[0] <= i_seg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_s;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Strobe on the edge that carries the count to STABLE, so downstream can register it there.
    assign o_s       = w_s;
    assign o_changed = w_changed;
    assign o_stable  = !w_changed && (r_cnt == STABLE - 8'd1);

endmodule

// File: rtl/seg7_sampler.sv
// Accepts a seven-segment pattern once stable, decodes it to hex, flags illegal patterns.
// Latency: pulse SYNC_STAGES + STABLE_CYC - 1 cycles after SEG settles. No backpressure.
module seg7_sampler
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [6:0] SEG,
    output logic       VALID,
    output logic [3:0] NUM,
    output logic       ERR,
    output logic [7:0] ERR_CNT
);

    logic [6:0]  w_s;
    logic        w_changed;
    logic        w_stable;
    logic        w_accept;
    seg7_dec_t   w_dec;
    seg7_state_t r_state;
    seg7_state_t w_state_nxt;

    logic        r_valid;
    logic        r_err;
    logic [3:0]  r_num;
    logic [7:0]  r_err_cnt;

    seg7_stable_filter #(
        .STABLE_CYC  (STABLE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_filter (
        .i_clk     (CLK),
        .i_rstn    (RSTN),
        .i_seg     (SEG),
        .o_s       (w_s),
        .o_changed (w_changed),
        .o_stable  (w_stable)
    );

    assign w_dec = seg7_decode(w_s);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                if (w_stable) begin
                    w_state_nxt = ST_LOCKED;
                    w_accept    = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_changed) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_SETTLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state   <= ST_SETTLE;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_num     <= 4'h0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_accept && w_dec.hit;
            r_err   <= w_accept && !w_dec.hit && (w_s != SEG_BLANK);
            if (w_accept && w_dec.hit) begin
                r_num <= w_dec.num;
            end
            if (w_accept && !w_dec.hit && (w_s != SEG_BLANK) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign VALID   = r_valid;
    assign ERR     = r_err;
    assign NUM     = r_num;
    assign ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_seg7_sampler.sv
// Randomized and directed bench for seg7_sampler with a run-length reference model and pulse scoreboard.
module tb_seg7_sampler;

    localparam int STABLE_CYC  = 16;
    localparam int SYNC_STAGES = 2;

    logic       CLK  = 1'b0;
    logic       RSTN = 1'b0;
    logic [6:0] SEG  = 7'h00;
    logic       VALID;
    logic       ERR;
    logic [3:0] NUM;
    logic [7:0] ERR_CNT;

    always #5 CLK = ~CLK;

    seg7_sampler #(
        .STABLE_CYC  (STABLE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .SEG     (SEG),
        .VALID   (VALID),
        .NUM     (NUM),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;

    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    function automatic int lookup(input logic [6:0] p);
        int idx = -1;
        for (int i = 0; i < 16; i++) if (hex_tab[i] == p) idx = i;
        return idx;
    endfunction

    typedef struct {
        bit       is_err;
        bit [3:0] num;
        bit [7:0] err_cnt;
    } exp_t;
    exp_t exp_q[$];

    // Reference: S is SEG delayed SYNC_STAGES edges; a run of STABLE_CYC identical S values is accepted once.
    bit [6:0] m_pipe [SYNC_STAGES];
    bit [6:0] m_run_val;
    bit [6:0] m_x;
    int       m_run_len;
    int       m_num;
    int       m_err_cnt;
    int       m_idx;
    exp_t     m_e;

    always @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 7'h00;
            m_run_val = 7'h00;
            m_run_len = 1;
            m_num     = 0;
            m_err_cnt = 0;
        end else begin
            m_x = m_pipe[SYNC_STAGES-1];
            if (m_x == m_run_val) begin
                if (m_run_len < STABLE_CYC) begin
                    m_run_len++;
                    if (m_run_len == STABLE_CYC) begin
                        m_idx = lookup(m_x);
                        if (m_idx >= 0) begin
                            m_num = m_idx;
                            m_e.is_err = 1'b0; m_e.num = 4'(m_num); m_e.err_cnt = 8'(m_err_cnt);
                            exp_q.push_back(m_e);
                        end else if (m_x != 7'h00) begin
                            if (m_err_cnt < 255) m_err_cnt++;
                            m_e.is_err = 1'b1; m_e.num = 4'(m_num); m_e.err_cnt = 8'(m_err_cnt);
                            exp_q.push_back(m_e);
                        end
                    end
                end
            end else begin
                m_run_val = m_x;
                m_run_len = 1;
            end
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = SEG;
        end
    end

    exp_t mon_e;
    always @(negedge CLK) begin
        checks++;
        if (VALID && ERR) begin
            errors++;
            $display("FAIL exclusive: VALID=%0b ERR=%0b both high, required not both", VALID, ERR);
        end
        if (VALID || ERR) begin
            if (VALID) n_valid++;
            if (ERR) n_err++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: VALID=%0b ERR=%0b NUM=%0h, required no pulse", VALID, ERR, NUM);
            end else begin
                mon_e = exp_q.pop_front();
                if (VALID !== !mon_e.is_err || ERR !== mon_e.is_err || NUM !== mon_e.num ||
                    ERR_CNT !== mon_e.err_cnt) begin
                    errors++;
                    $display("FAIL pulse: got VALID=%0b ERR=%0b NUM=%0h ERR_CNT=%0d, required VALID=%0b ERR=%0b NUM=%0h ERR_CNT=%0d",
                             VALID, ERR, NUM, ERR_CNT, !mon_e.is_err, mon_e.is_err, mon_e.num, mon_e.err_cnt);
                end
            end
        end else if (exp_q.size() > 0) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL missed_pulse: got none, required %s NUM=%0h", mon_e.is_err ? "ERR" : "VALID", mon_e.num);
        end
        checks++;
        if (NUM !== 4'(m_num) || ERR_CNT !== 8'(m_err_cnt)) begin
            errors++;
            $display("FAIL held_state: got NUM=%0h ERR_CNT=%0d, required NUM=%0h ERR_CNT=%0d",
                     NUM, ERR_CNT, m_num, m_err_cnt);
        end
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic hold(input logic [6:0] p, input int n);
        SEG = p;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        RSTN = 1'b0;
        repeat (n) @(negedge CLK);
        RSTN = 1'b1;
    endtask

    // Edge 1 is the first rising edge after the call.
    task automatic measure(output int first, output int nv, input int win);
        first = -1;
        nv = 0;
        for (int i = 1; i <= win; i++) begin
            @(posedge CLK);
            #1;
            if (VALID) begin
                nv++;
                if (first < 0) first = i;
            end
        end
        @(negedge CLK);
    endtask

    int first, nv, v0, e0;
    logic [6:0] p;

    initial begin
        @(negedge CLK);
        do_reset(3);
        check_eq("reset_valid", int'(VALID), 0);
        check_eq("reset_err", int'(ERR), 0);
        check_eq("reset_num", int'(NUM), 0);
        check_eq("reset_err_cnt", int'(ERR_CNT), 0);

        // Latency from the first sampling edge, one pulse despite the long hold.
        SEG = 7'h5B;
        measure(first, nv, 40);
        check_eq("lat_5B_edge", first, 1 + SYNC_STAGES + STABLE_CYC - 1);
        check_eq("lat_5B_count", nv, 1);
        check_eq("lat_5B_num", int'(NUM), 5);

        v0 = n_valid; e0 = n_err;
        hold(7'h7E, 20);
        check_eq("seq_7E_num", int'(NUM), 0);
        hold(7'h30, 20);
        check_eq("seq_30_num", int'(NUM), 1);
        check_eq("seq_valid_count", n_valid - v0, 2);
        check_eq("seq_err_count", n_err - e0, 0);

        // Glitch is never reported; resumed 7E settles again and is re-accepted as 0.
        hold(7'h7E, 30);
        v0 = n_valid; e0 = n_err;
        hold(7'h30, 3);
        hold(7'h7E, 30);
        check_eq("glitch_num", int'(NUM), 0);
        check_eq("glitch_valid_count", n_valid - v0, 1);
        check_eq("glitch_err_count", n_err - e0, 0);

        do_reset(1);
        hold(7'h7F, 20);
        hold(7'h01, 20);
        check_eq("err_once_cnt", int'(ERR_CNT), 1);
        check_eq("err_once_num", int'(NUM), 8);
        for (int i = 0; i < 300; i++) begin
            hold(7'h01, 20);
            hold(7'h00, 20);
        end
        check_eq("err_saturate", int'(ERR_CNT), 255);
        check_eq("err_sat_num", int'(NUM), 8);

        do_reset(2);
        v0 = n_valid; e0 = n_err;
        hold(7'h00, 20);
        check_eq("blank_pulses", (n_valid - v0) + (n_err - e0), 0);
        hold(7'h7F, 20);
        check_eq("blank_then_8_num", int'(NUM), 8);
        hold(7'h00, 20);
        hold(7'h7F, 20);
        check_eq("blank_8_valid_count", n_valid - v0, 2);
        check_eq("blank_8_err_count", n_err - e0, 0);

        // Reset mid-settle restarts the full acceptance delay.
        hold(7'h00, 20);
        SEG = 7'h47;
        repeat (10) @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        measure(first, nv, 40);
        check_eq("rst_mid_edge", first, 1 + SYNC_STAGES + STABLE_CYC - 1);
        check_eq("rst_mid_count", nv, 1);
        check_eq("rst_mid_num", int'(NUM), 15);

        for (int seg_i = 0; seg_i < 200; seg_i++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            case ($urandom_range(0, 5))
                0, 1, 2: p = hex_tab[$urandom_range(0, 15)];
                3:       p = 7'h00;
                default: begin
                    p = 7'($urandom);
                    while (lookup(p) >= 0 || p == 7'h00) p = 7'($urandom);
                end
            endcase
            if ($urandom_range(0, 2) == 0) hold(p, $urandom_range(1, STABLE_CYC - 1));
            else hold(p, $urandom_range(STABLE_CYC - 2, 40));
        end
        hold(7'h00, 40);
        check_eq("drain_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
